// File: rtl/uart_rx_param_if.sv
// Word-side port bundle of uart_rx_param: received word, error flags, busy,
// FSM state for observation, and the consumer's ready.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  // Handshake: o_RxValid rises with a new word and its flags, and all of them hold
  // steady until a rising edge sees o_RxValid && i_RxReady. That edge accepts the word.
  // o_RxValid then drops unless another frame completes on the same edge.
  logic [DATA_BITS-1:0] o_RxData;
  logic                 o_RxValid;
  logic                 i_RxReady;
  logic                 o_ParityErr;
  logic                 o_FrameErr;
  logic                 o_Overrun;
  logic                 o_Busy;
  logic [2:0]           dbg_state;

  modport master (
    output o_RxData, o_RxValid, o_ParityErr, o_FrameErr, o_Overrun, o_Busy, dbg_state,
    input  i_RxReady
  );

  modport slave (
    input  o_RxData, o_RxValid, o_ParityErr, o_FrameErr, o_Overrun, o_Busy, dbg_state,
    output i_RxReady
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// false-start rejection, and valid/ready word output with error flags.
module uart_rx_param #(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic            i_SysClock,
  input  logic            i_Reset,
  input  logic            i_RxSerial,
  uart_rx_param_if.master rx_if
);

  localparam int          BIT_TICKS  = SYS_CLOCK / UART_BAUDRATE;
  localparam int          HALF_TICKS = BIT_TICKS / 2;
  localparam logic [15:0] BIT_TC     = 16'(BIT_TICKS - 1);
  localparam logic [15:0] HALF_TC    = 16'(HALF_TICKS - 1);
  localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic        ODD_PAR    = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 rx_s_q, rx_s_d;
  logic [15:0]          tick_q, tick_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;
  logic                 tc;
  logic                 frame_done;

  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    sync1_d    = i_RxSerial;
    rx_s_d     = sync1_q;
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    armed_d    = armed_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;
    frame_done = 1'b0;
    tc         = (state_q == S_START) ? (tick_q == HALF_TC) : (tick_q == BIT_TC);

    case (state_q)
      S_IDLE: begin
        // A start is only honoured once the line has been seen high, so a held break cannot retrigger.
        if (armed_q && !rx_s_q) begin
          state_d = S_START;
          armed_d = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end else if (rx_s_q) begin
          armed_d = 1'b1;
        end
      end
      S_START: begin
        if (tc) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (tc) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (PARITY != 0) state_d = S_PARITY;
            else             state_d = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tc) begin
          perr_d  = ((^shift_q) ^ rx_s_q) != ODD_PAR;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tc) begin
          ferr_d    = ferr_q | ~rx_s_q;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d  = '0;
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || tc || state_q == S_IDLE) tick_d = '0;
    else                                               tick_d = tick_q + 16'd1;

    // A completing frame wins over an accept on the same edge; if the old word is
    // neither free nor being taken, the new one is dropped and flagged.
    if (frame_done) begin
      if (!valid_q || rx_if.i_RxReady) begin
        data_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_d;
        valid_d    = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end else if (valid_q && rx_if.i_RxReady) begin
      valid_d = 1'b0;
    end
  end

  assign rx_if.o_RxData    = data_q;
  assign rx_if.o_RxValid   = valid_q;
  assign rx_if.o_ParityErr = perr_out_q;
  assign rx_if.o_FrameErr  = ferr_out_q;
  assign rx_if.o_Overrun   = overrun_q;
  assign rx_if.o_Busy      = (state_q != S_IDLE);
  assign rx_if.dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four receiver configurations on a 16-tick bit period,
// checked against a frame-level reference model.
module tb_uart_rx_param;
  localparam int BT  = 16;
  localparam int D_A = 0, D_E = 1, D_O = 2, D_S = 3;
  localparam int L_A = 0, L_P = 1, L_S = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst     = 1'b1;
  logic rst_mid = 1'b0;
  logic ser_a   = 1'b1;
  logic ser_p   = 1'b1;
  logic ser_s   = 1'b1;
  logic rdy_a   = 1'b1;

  int checks = 0;
  int errors = 0;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(7)) if_e ();
  uart_rx_param_if #(.DATA_BITS(7)) if_o ();
  uart_rx_param_if #(.DATA_BITS(8)) if_s ();
  assign if_a.i_RxReady = rdy_a;
  assign if_e.i_RxReady = 1'b1;
  assign if_o.i_RxReady = 1'b1;
  assign if_s.i_RxReady = 1'b1;

  uart_rx_param #(.SYS_CLOCK(16), .UART_BAUDRATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_a (.i_SysClock(clk), .i_Reset(rst | rst_mid), .i_RxSerial(ser_a), .rx_if(if_a));
  uart_rx_param #(.SYS_CLOCK(16), .UART_BAUDRATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
    u_e (.i_SysClock(clk), .i_Reset(rst), .i_RxSerial(ser_p), .rx_if(if_e));
  uart_rx_param #(.SYS_CLOCK(16), .UART_BAUDRATE(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1))
    u_o (.i_SysClock(clk), .i_Reset(rst), .i_RxSerial(ser_p), .rx_if(if_o));
  uart_rx_param #(.SYS_CLOCK(16), .UART_BAUDRATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    u_s (.i_SysClock(clk), .i_Reset(rst), .i_RxSerial(ser_s), .rx_if(if_s));

  // scoreboard: accepted words as {perr, ferr, data[8:0]}
  logic [10:0] exp_q[$];
  logic [10:0] cap_a[$], cap_e[$], cap_o[$], cap_s[$];
  int vhigh_a = 0;
  int ovr_a   = 0;

  always @(negedge clk) begin
    #1;
    if (if_a.o_RxValid && if_a.i_RxReady) cap_a.push_back({if_a.o_ParityErr, if_a.o_FrameErr, 1'b0, if_a.o_RxData});
    if (if_e.o_RxValid && if_e.i_RxReady) cap_e.push_back({if_e.o_ParityErr, if_e.o_FrameErr, 2'b00, if_e.o_RxData});
    if (if_o.o_RxValid && if_o.i_RxReady) cap_o.push_back({if_o.o_ParityErr, if_o.o_FrameErr, 2'b00, if_o.o_RxData});
    if (if_s.o_RxValid && if_s.i_RxReady) cap_s.push_back({if_s.o_ParityErr, if_s.o_FrameErr, 1'b0, if_s.o_RxData});
    if (if_a.o_RxValid) vhigh_a++;
    if (if_a.o_Overrun) ovr_a++;
  end

  // reference model: line bits of a frame, and the word a receiver must report for it
  task automatic build_frame(input logic [8:0] data, input int nbits, input int par, input logic pbit,
                             input logic [1:0] stops, input int nstop,
                             output logic [15:0] f, output int len);
    int k;
    f    = '1;
    f[0] = 1'b0;
    k    = 1;
    for (int i = 0; i < nbits; i++) begin f[k] = data[i]; k++; end
    if (par != 0) begin f[k] = pbit; k++; end
    for (int i = 0; i < nstop; i++) begin f[k] = stops[i]; k++; end
    len = k;
  endtask

  function automatic logic [10:0] expect_word(input logic [8:0] data, input int nbits, input int par,
                                              input logic pbit, input logic [1:0] stops, input int nstop);
    logic [8:0] d;
    logic       pe, fe;
    int         ones;
    d    = data & ((9'd1 << nbits) - 9'd1);
    ones = $countones(d) + int'(pbit);
    if (par == 1)      pe = (ones % 2 == 0);
    else if (par == 2) pe = (ones % 2 == 1);
    else               pe = 1'b0;
    fe = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) fe = 1'b1;
    return {pe, fe, d};
  endfunction

  // driver tasks
  task automatic set_line(input int line, input logic v);
    case (line)
      L_A:     ser_a = v;
      L_P:     ser_p = v;
      default: ser_s = v;
    endcase
  endtask

  task automatic drive_bits(input int line, input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      set_line(line, bits[i]);
      repeat (BT - 1) @(negedge clk);
    end
  endtask

  task automatic send(input int line, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    logic [15:0] f;
    int          len;
    case (line)
      L_A:     build_frame(data, 8, 0, pbit, stops, 1, f, len);
      L_P:     build_frame(data, 7, 2, pbit, stops, 1, f, len);
      default: build_frame(data, 8, 0, pbit, stops, 2, f, len);
    endcase
    drive_bits(line, f, len);
  endtask

  task automatic idle(input int line, input int nbits);
    @(negedge clk);
    set_line(line, 1'b1);
    repeat (nbits * BT - 1) @(negedge clk);
  endtask

  task automatic get_cap(input int dut, output logic [10:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      case (dut)
        D_A:     if (cap_a.size() != 0) begin w = cap_a.pop_front(); ok = 1'b1; end
        D_E:     if (cap_e.size() != 0) begin w = cap_e.pop_front(); ok = 1'b1; end
        D_O:     if (cap_o.size() != 0) begin w = cap_o.pop_front(); ok = 1'b1; end
        default: if (cap_s.size() != 0) begin w = cap_s.pop_front(); ok = 1'b1; end
      endcase
      if (!ok) @(posedge clk);
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({if_a.o_RxValid, if_a.o_ParityErr, if_a.o_FrameErr, if_a.o_Overrun, if_a.o_Busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000", {if_a.o_RxValid, if_a.o_ParityErr, if_a.o_FrameErr, if_a.o_Overrun, if_a.o_Busy});
    end
    checks++;
    if (if_a.o_RxData !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", if_a.o_RxData); end
    rst = 1'b0;
    idle(L_A, 1);
  endtask

  task automatic test_basic();
    logic [10:0] w, exp;
    bit          ok;
    int          vh0;
    vh0 = vhigh_a;
    exp_q.push_back(expect_word(9'h0A5, 8, 0, 1'b0, 2'b11, 1));
    send(L_A, 9'h0A5, 1'b0, 2'b11);
    get_cap(D_A, w, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || w !== exp) begin errors++; $display("FAIL basic_a5 got=%h ok=%0d exp=%h", w, ok, exp); end
    checks++;
    if (vhigh_a - vh0 != 1) begin errors++; $display("FAIL basic_valid_width got=%0d exp=1", vhigh_a - vh0); end
    exp_q.push_back(expect_word(9'h000, 8, 0, 1'b0, 2'b11, 1));
    exp_q.push_back(expect_word(9'h0FF, 8, 0, 1'b0, 2'b11, 1));
    send(L_A, 9'h000, 1'b0, 2'b11);
    send(L_A, 9'h0FF, 1'b0, 2'b11);
    for (int i = 0; i < 2; i++) begin
      get_cap(D_A, w, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || w !== exp) begin errors++; $display("FAIL back_to_back_%0d got=%h ok=%0d exp=%h", i, w, ok, exp); end
    end
  endtask

  task automatic test_parity();
    logic [10:0] w, exp_e, exp_o;
    bit          ok;
    for (int p = 0; p < 2; p++) begin
      exp_e = expect_word(9'h035, 7, 2, p[0], 2'b11, 1);
      exp_o = expect_word(9'h035, 7, 1, p[0], 2'b11, 1);
      send(L_P, 9'h035, p[0], 2'b11);
      get_cap(D_E, w, ok);
      checks++;
      if (!ok || w !== exp_e) begin errors++; $display("FAIL parity_even_p%0d got=%h ok=%0d exp=%h", p, w, ok, exp_e); end
      get_cap(D_O, w, ok);
      checks++;
      if (!ok || w !== exp_o) begin errors++; $display("FAIL parity_odd_p%0d got=%h ok=%0d exp=%h", p, w, ok, exp_o); end
    end
    idle(L_P, 1);
  endtask

  task automatic test_stop2_break();
    logic [10:0] w, exp;
    bit          ok;
    exp = expect_word(9'h03C, 8, 0, 1'b0, 2'b01, 2);
    send(L_S, 9'h03C, 1'b0, 2'b01);
    get_cap(D_S, w, ok);
    checks++;
    if (!ok || w !== exp) begin errors++; $display("FAIL stop2_ferr got=%h ok=%0d exp=%h", w, ok, exp); end
    repeat (40 * BT) @(negedge clk);
    checks++;
    if (cap_s.size() != 0 || if_s.o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL break_hold got_words=%0d busy=%b exp_words=0 busy=0", cap_s.size(), if_s.o_Busy);
    end
    idle(L_S, 2);
    exp = expect_word(9'h099, 8, 0, 1'b0, 2'b11, 2);
    send(L_S, 9'h099, 1'b0, 2'b11);
    get_cap(D_S, w, ok);
    checks++;
    if (!ok || w !== exp) begin errors++; $display("FAIL after_break got=%h ok=%0d exp=%h", w, ok, exp); end
  endtask

  task automatic test_false_start();
    logic [10:0] w, exp;
    bit          ok;
    int          n;
    @(negedge clk);
    ser_a = 1'b0;
    repeat (5) @(negedge clk);
    ser_a = 1'b1;
    n = 0;
    while (if_a.o_Busy !== 1'b0 && n < 12) begin @(negedge clk); n++; end
    checks++;
    if (if_a.o_Busy !== 1'b0) begin errors++; $display("FAIL false_start_busy got=%b exp=0", if_a.o_Busy); end
    repeat (BT) @(negedge clk);
    checks++;
    if (cap_a.size() != 0) begin errors++; $display("FAIL false_start_word got=%0d exp=0", cap_a.size()); end
    exp = expect_word(9'h05A, 8, 0, 1'b0, 2'b11, 1);
    send(L_A, 9'h05A, 1'b0, 2'b11);
    get_cap(D_A, w, ok);
    checks++;
    if (!ok || w !== exp) begin errors++; $display("FAIL after_false_start got=%h ok=%0d exp=%h", w, ok, exp); end
  endtask

  task automatic test_overrun();
    logic [10:0] w, exp;
    bit          ok;
    int          ov0;
    ov0 = ovr_a;
    @(negedge clk);
    rdy_a = 1'b0;
    exp_q.push_back(expect_word(9'h011, 8, 0, 1'b0, 2'b11, 1));
    send(L_A, 9'h011, 1'b0, 2'b11);
    send(L_A, 9'h022, 1'b0, 2'b11);
    exp = exp_q.pop_front();
    checks++;
    if (ovr_a - ov0 != 1) begin errors++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_a - ov0); end
    checks++;
    if (if_a.o_RxValid !== 1'b1 || {if_a.o_ParityErr, if_a.o_FrameErr, 1'b0, if_a.o_RxData} !== exp) begin
      errors++;
      $display("FAIL overrun_hold got_valid=%b word=%h exp_valid=1 word=%h", if_a.o_RxValid,
               {if_a.o_ParityErr, if_a.o_FrameErr, 1'b0, if_a.o_RxData}, exp);
    end
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    checks++;
    if (if_a.o_RxValid !== 1'b0 || if_a.o_RxData !== 8'h11) begin
      errors++;
      $display("FAIL accept_drop got_valid=%b data=%h exp_valid=0 data=11", if_a.o_RxValid, if_a.o_RxData);
    end
    get_cap(D_A, w, ok);
    checks++;
    if (!ok || w !== exp) begin errors++; $display("FAIL accepted_word got=%h ok=%0d exp=%h", w, ok, exp); end
    rdy_a = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [10:0] w, exp;
    logic [15:0] f;
    int          len;
    bit          ok;
    build_frame(9'h081, 8, 0, 1'b0, 2'b11, 1, f, len);
    drive_bits(L_A, f, 4);
    @(negedge clk);
    ser_a = f[4];
    repeat (8) @(negedge clk);
    checks++;
    if (if_a.o_Busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy got=%b exp=1", if_a.o_Busy); end
    rst_mid = 1'b1;
    @(negedge clk);
    rst_mid = 1'b0;
    ser_a   = 1'b1;
    checks++;
    if ({if_a.o_RxValid, if_a.o_ParityErr, if_a.o_FrameErr, if_a.o_Overrun, if_a.o_Busy, if_a.o_RxData} !== 13'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%b exp=0", {if_a.o_RxValid, if_a.o_ParityErr, if_a.o_FrameErr, if_a.o_Overrun, if_a.o_Busy, if_a.o_RxData});
    end
    repeat (12 * BT) @(negedge clk);
    checks++;
    if (cap_a.size() != 0) begin errors++; $display("FAIL reset_mid_word got=%0d exp=0", cap_a.size()); end
    exp = expect_word(9'h07E, 8, 0, 1'b0, 2'b11, 1);
    send(L_A, 9'h07E, 1'b0, 2'b11);
    get_cap(D_A, w, ok);
    checks++;
    if (!ok || w !== exp) begin errors++; $display("FAIL after_reset_mid got=%h ok=%0d exp=%h", w, ok, exp); end
  endtask

  task automatic test_random();
    logic [10:0] w, exp_e, exp_o;
    logic [8:0]  d;
    logic [1:0]  st;
    logic        pb;
    bit          ok;
    for (int i = 0; i < 10; i++) begin
      d = 9'($urandom_range(0, 255));
      exp_q.push_back(expect_word(d, 8, 0, 1'b0, 2'b11, 1));
      idle(L_A, $urandom_range(0, 2) + 1);
      send(L_A, d, 1'b0, 2'b11);
      get_cap(D_A, w, ok);
      exp_e = exp_q.pop_front();
      checks++;
      if (!ok || w !== exp_e) begin errors++; $display("FAIL rand_a_%0d got=%h ok=%0d exp=%h", i, w, ok, exp_e); end

      d  = 9'($urandom_range(0, 127));
      pb = 1'($urandom_range(0, 1));
      exp_e = expect_word(d, 7, 2, pb, 2'b11, 1);
      exp_o = expect_word(d, 7, 1, pb, 2'b11, 1);
      send(L_P, d, pb, 2'b11);
      get_cap(D_E, w, ok);
      checks++;
      if (!ok || w !== exp_e) begin errors++; $display("FAIL rand_e_%0d got=%h ok=%0d exp=%h", i, w, ok, exp_e); end
      get_cap(D_O, w, ok);
      checks++;
      if (!ok || w !== exp_o) begin errors++; $display("FAIL rand_o_%0d got=%h ok=%0d exp=%h", i, w, ok, exp_o); end

      d  = 9'($urandom_range(0, 255));
      st = 2'($urandom_range(0, 3));
      exp_e = expect_word(d, 8, 0, 1'b0, st, 2);
      idle(L_S, 1);
      send(L_S, d, 1'b0, st);
      get_cap(D_S, w, ok);
      checks++;
      if (!ok || w !== exp_e) begin errors++; $display("FAIL rand_s_%0d got=%h ok=%0d exp=%h", i, w, ok, exp_e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2_break();
    test_false_start();
    test_overrun();
    test_reset_mid();
    test_random();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end
endmodule
